twiddle_gen: RTL
================

TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 SHALL have parameter W, default `BITS (from define.v): signed twiddle output width.
REQ-002 SHALL have parameter FRAC, default 21: fraction bits, so 1.0 = 2097152.
REQ-003 SHALL have parameter LOG2_MAX, default 10: largest FFT size MAX_N = 2^LOG2_MAX.
REQ-004 SHALL have port clk  in  1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port start  in  1: one-cycle request to begin a sequence.
REQ-007 SHALL have port log2n  in  4: log2 of stage size N for the request.
REQ-008 SHALL have port inv  in  1: 1 = inverse transform (conjugate twiddles).
REQ-009 SHALL have port out_ready  in  1: consumer accepts the current twiddle.
REQ-010 SHALL have port out_valid  out  1: cos_o/sin_o/out_idx/last are valid.
REQ-011 SHALL have port cos_o  out  W signed: Re(W_N^k), Q(FRAC).
REQ-012 SHALL have port sin_o  out  W signed: Im(W_N^k), Q(FRAC).
REQ-013 SHALL have port out_idx  out  LOG2_MAX: current k.
REQ-014 SHALL have port last  out  1: high with the final twiddle, k = N/2-1.
REQ-015 SHALL have port busy  out  1: a sequence is in progress.
REQ-016 SHALL have port err  out  1: one-cycle pulse on a rejected start.

Function
REQ-017 SHALL emit W_N^k = exp(-j2πk/N) for k = 0..N/2-1, in order, one per accepted handshake.
REQ-018 SHALL use states IDLE and RUN; IDLE->RUN on start with 1<=log2n<=LOG2_MAX; RUN->IDLE on handshake (out_valid & out_ready) with last=1.
REQ-019 SHALL assert out_valid in the cycle after start is accepted, with k=0.
REQ-020 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-021 SHALL advance k on a handshake, presenting the next twiddle in the following cycle without bubbles (sustains one per cycle).
REQ-022 SHALL address a quarter-wave table S[i] = round(sin(2πi/MAX_N)*2^FRAC), i=0..MAX_N/4, at a = k << (LOG2_MAX-log2n).
REQ-023 SHALL compute, with Q = MAX_N/4: for a<=Q, cos=S[Q-a], s=S[a]; for a>Q, cos=-S[a-Q], s=S[MAX_N/2-a].
REQ-024 SHALL drive sin_o = -s when inv=0 and sin_o = +s when inv=1; inv and log2n are latched at start.
REQ-025 SHALL treat log2n=1 (N=2) as a one-element sequence: (2^FRAC, 0) with last=1.
REQ-026 SHALL ignore start and pulse err for one cycle when log2n=0 or log2n>LOG2_MAX.
REQ-027 SHALL ignore start while busy=1 (no err pulse); busy = (state==RUN).
REQ-028 SHALL perform negation in W bits; table values never exceed 2^FRAC, so no saturation is needed.

Reset
REQ-029 SHALL on rst=1 enter IDLE and zero out_valid, cos_o, sin_o, out_idx, last, busy and err in the next cycle.
REQ-030 SHALL let rst abort a sequence mid-run; no further twiddles from that sequence appear.
REQ-031 SHALL give rst priority over a simultaneous start.

Configuration
REQ-032 SHALL honour macro TWIDDLE_INV_EN: when defined, inv behaves per REQ-024.
REQ-033 SHALL, without TWIDDLE_INV_EN, ignore inv and always emit forward twiddles (sin_o = -s).

Structure
REQ-034 SHALL place W/FRAC defaults, the state encoding and the Q/MAX_N constants in a shared package twiddle_pkg.
REQ-035 SHALL contain one sub-module twiddle_rom: a combinational, dual-read quarter-wave table parametrised by LOG2_MAX and FRAC.

Verification
REQ-036 SHALL check: log2n=2, inv=0, out_ready=1 -> (2097152,0) then (0,-2097152) with last, busy falls.
REQ-037 SHALL check: log2n=3, inv=0 -> k=1 gives (1482910,-1482910); with inv=1 (macro on) sin_o=+1482910.
REQ-038 SHALL check: log2n=7 -> k=1 sin_o=-102902; 64 twiddles, last only on k=63.
REQ-039 SHALL check: out_ready low 3 cycles at k=2 -> outputs frozen, no k skipped or repeated.
REQ-040 SHALL check: rst at k=3 of N=16 -> next cycle all outputs 0, IDLE; a new start works.
REQ-041 SHALL check: start with log2n=0 or 11 -> err one cycle, busy stays 0; start while busy -> ignored.

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared constants and state encoding for the FFT twiddle generator.
// Defaults: 24-bit signed output, Q21 fraction, tables sized for a 1024-point FFT.
package twiddle_pkg;

  localparam int TW_W        = 24;
  localparam int TW_FRAC     = 21;
  localparam int TW_LOG2_MAX = 10;
  localparam int TW_MAX_N    = 1 << TW_LOG2_MAX;
  localparam int TW_Q        = TW_MAX_N / 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/twiddle_rom.sv
// Quarter-wave sine table S[i] = round(sin(2*pi*i/MAX_N) * 2^FRAC), i = 0..MAX_N/4.
// The table is built at elaboration; two independent combinational read ports.
module twiddle_rom #(
  parameter int LOG2_MAX = 10,
  parameter int FRAC     = 21,
  parameter int W        = 24
) (
  input  logic        [LOG2_MAX-2:0] addr_a,
  input  logic        [LOG2_MAX-2:0] addr_b,
  output logic signed [W-1:0]        data_a,
  output logic signed [W-1:0]        data_b
);

  localparam int  QW = (1 << LOG2_MAX) / 4;
  localparam real PI = 3.14159265358979323846;

  logic signed [W-1:0] rom [0:QW];

  // Every entry is non-negative, so adding 0.5 before truncation rounds to nearest.
  for (genvar i = 0; i <= QW; i++) begin : g_tab
    localparam real ANG = 2.0 * PI * real'(i) / real'(1 << LOG2_MAX);
    assign rom[i] = W'($rtoi($sin(ANG) * (2.0 ** FRAC) + 0.5));
  end

  assign data_a = rom[addr_a];
  assign data_b = rom[addr_b];

endmodule

// File: rtl/twiddle_gen.sv
// Streams W_N^k = exp(-j*2*pi*k/N), k = 0..N/2-1, over a valid/ready handshake.
// Define TWIDDLE_INV_EN to honour inv (conjugate twiddles); otherwise inv is ignored.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int W        = TW_W,
  parameter int FRAC     = TW_FRAC,
  parameter int LOG2_MAX = TW_LOG2_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            log2n,
  input  logic                  inv,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic signed [W-1:0]   cos_o,
  output logic signed [W-1:0]   sin_o,
  output logic [LOG2_MAX-1:0]   out_idx,
  output logic                  last,
  output logic                  busy,
  output logic                  err
);

  localparam int AW   = LOG2_MAX;
  localparam int RW   = LOG2_MAX - 1;
  localparam int MAXN = 1 << LOG2_MAX;
  localparam int QW   = MAXN / 4;
  localparam logic [AW-1:0] QV = AW'(QW);
  localparam logic [AW-1:0] HV = AW'(MAXN / 2);

  state_t              state;
  logic [3:0]          log2n_q;
  logic                inv_q;
  logic                hs, bad, accept, inv_eff, low;
  logic [3:0]          lg, shamt;
  logic [AW-1:0]       k_next, a, half_m1;
  logic [RW-1:0]       cos_addr, sin_addr;
  logic signed [W-1:0] cos_s, sin_s, cos_n, sin_n;

  assign hs     = out_valid & out_ready;
  assign bad    = (log2n == 4'd0) || (log2n > 4'(LOG2_MAX));
  assign accept = (state == IDLE) && start && !bad;

  // On accept the request's own log2n/inv apply to k=0, before they are latched.
  assign lg      = accept ? log2n : log2n_q;
  assign shamt   = 4'(LOG2_MAX) - lg;
  assign k_next  = accept ? '0 : out_idx + AW'(1);
  assign a       = k_next << shamt;
  assign half_m1 = (AW'(1) << (lg - 4'd1)) - AW'(1);
  assign low     = (a <= QV);

`ifdef TWIDDLE_INV_EN
  assign inv_eff = accept ? inv : inv_q;
`else
  logic unused_inv;
  assign unused_inv = inv ^ inv_q;
  assign inv_eff    = 1'b0;
`endif

  always_comb begin
    cos_addr = '0;
    sin_addr = '0;
    if (low) begin
      cos_addr = RW'(QV - a);
      sin_addr = RW'(a);
    end else begin
      cos_addr = RW'(a - QV);
      sin_addr = RW'(HV - a);
    end
  end

  twiddle_rom #(.LOG2_MAX(LOG2_MAX), .FRAC(FRAC), .W(W)) u_rom (
    .addr_a (cos_addr),
    .addr_b (sin_addr),
    .data_a (cos_s),
    .data_b (sin_s)
  );

  assign cos_n = low ? cos_s : -cos_s;
  assign sin_n = inv_eff ? sin_s : -sin_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      log2n_q   <= '0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      cos_o     <= '0;
      sin_o     <= '0;
      out_idx   <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && bad) begin
            err <= 1'b1;
          end else if (accept) begin
            state     <= RUN;
            busy      <= 1'b1;
            log2n_q   <= log2n;
            inv_q     <= inv;
            out_valid <= 1'b1;
            cos_o     <= cos_n;
            sin_o     <= sin_n;
            out_idx   <= k_next;
            last      <= (k_next == half_m1);
          end
        end
        RUN: begin
          if (hs) begin
            if (last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              last      <= 1'b0;
            end else begin
              cos_o   <= cos_n;
              sin_o   <= sin_n;
              out_idx <= k_next;
              last    <= (k_next == half_m1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
